// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply and divide datapaths.
// Decodes start pulses, latches operands, strobes the datapaths for a fixed
// number of iterations, then registers the selected result with a ready pulse.
module multdiv_ctrl #(
  parameter int MULT_ITERS = 16,
  parameter int DIV_ITERS  = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] dp_operandA,
  output logic [31:0] dp_operandB,
  output logic        mult_load,
  output logic        mult_enable,
  output logic        div_load,
  output logic        div_enable,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [2:0] {
    IDLE,
    MRUN,
    DRUN,
    CAPT_M,
    CAPT_D
  } ctrlState_t;

  localparam logic [CNT_W-1:0] multLast = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] divLast  = CNT_W'(DIV_ITERS - 1);

  ctrlState_t       state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic [31:0]      opA, opB;
  logic             startM, startD, anyStart;
  logic             captM, captD;

  // Start decode: a simultaneous MULT and DIV keeps the MULT and drops the DIV.
  assign startM   = ctrl_MULT;
  assign startD   = ctrl_DIV & ~ctrl_MULT;
  assign anyStart = startM | startD;

  // Load strobes pass straight through so the datapath loads on the start edge.
  assign mult_load   = startM;
  assign div_load    = startD;
  assign mult_enable = (state == MRUN);
  assign div_enable  = (state == DRUN);

  // Operands reach the datapath in the start cycle, then come from the latches.
  assign dp_operandA = anyStart ? data_operandA : opA;
  assign dp_operandB = anyStart ? data_operandB : opB;

  // Next-state and iteration count; a start from any state restarts the sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
    stateNext = state;
    countNext = count;
    captM     = 1'b0;
    captD     = 1'b0;
    if (startM) begin
      stateNext = MRUN;
      countNext = '0;
    end else if (startD) begin
      stateNext = DRUN;
      countNext = '0;
    end else begin
      unique case (state)
        MRUN: begin
          if (count == multLast) begin
            stateNext = CAPT_M;
            countNext = '0;
          end else begin
            countNext = count + 1'b1;
          end
        end
        DRUN: begin
          if (count == divLast) begin
            stateNext = CAPT_D;
            countNext = '0;
          end else begin
            countNext = count + 1'b1;
          end
        end
        CAPT_M: begin
          stateNext = IDLE;
          captM     = 1'b1;
        end
        CAPT_D: begin
          stateNext = IDLE;
          captD     = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State, counter and operand latches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      opA   <= '0;
      opB   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= stateNext;
      count <= countNext;
      if (anyStart) begin
        opA <= data_operandA;
        opB <= data_operandB;
      end
    end
  end

  // Result register and one-cycle ready pulse, loaded only from an uninterrupted capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= captM | captD;
      if (captM) begin
        data_result    <= mult_result;
        data_exception <= mult_exception;
      end else if (captD) begin
        data_result    <= div_result;
        data_exception <= div_exception;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected results with the
// cycle RDY must appear in; a negedge monitor pops and compares on every RDY.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] dp_operandA, dp_operandB;
  logic        mult_load, mult_enable, div_load, div_enable;
  logic [31:0] mult_result, div_result;
  logic        mult_exception, div_exception;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  multdiv_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .dp_operandA   (dp_operandA),
    .dp_operandB   (dp_operandB),
    .mult_load     (mult_load),
    .mult_enable   (mult_enable),
    .div_load      (div_load),
    .div_enable    (div_enable),
    .mult_result   (mult_result),
    .mult_exception(mult_exception),
    .div_result    (div_result),
    .div_exception (div_exception),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  // Cycle index: cycle n lies between rising edges n and n+1.
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cycle;
  } expect_t;

  expect_t sb[$];
  int tests = 0;
  int fails = 0;

  int mEnCnt, mEnFirst, mEnLast;
  int dEnCnt, dEnFirst, dEnLast;
  int rdyCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearStats();
    mEnCnt = 0; mEnFirst = -1; mEnLast = -1;
    dEnCnt = 0; dEnFirst = -1; dEnLast = -1;
    rdyCnt = 0;
  endtask

  // Monitor: strobe statistics plus scoreboard comparison on every RDY.
  always @(negedge clock) begin
    if (mult_enable === 1'b1) begin
      if (mEnCnt == 0) mEnFirst = cyc;
      mEnLast = cyc;
      mEnCnt++;
    end
    if (div_enable === 1'b1) begin
      if (dEnCnt == 0) dEnFirst = cyc;
      dEnLast = cyc;
      dEnCnt++;
    end
    if (data_resultRDY === 1'b1) begin
      expect_t e;
      rdyCnt++;
      if (sb.size() == 0) begin
        check("unexpectedRdy", 32'(data_resultRDY), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdyCycle", 32'(cyc), 32'(e.cycle));
        check("result", data_result, e.res);
        check("exception", 32'(data_exception), 32'(e.exc));
      end
    end
  end

  // Issue a start at a falling edge; the start cycle index is returned.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic expRdy, input logic [31:0] res, input logic exc,
                       output int startCyc);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    startCyc      = cyc;
    if (expRdy) sb.push_back('{res: res, exc: exc, cycle: cyc + (m ? 18 : 34)});
    #1;
    check("multLoad", 32'(mult_load), 32'(m));
    check("divLoad", 32'(div_load), 32'(d & ~m));
    check("dpOpAStart", dp_operandA, a);
    check("dpOpBStart", dp_operandB, b);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = 32'hDEAD_BEEF;
    #1;
    check("dpOpAHeld", dp_operandA, a);
    check("dpOpBHeld", dp_operandB, b);
  endtask

  int c0, c1;

  initial begin
    reset_n        = 1'b0;
    ctrl_MULT      = 1'b0;
    ctrl_DIV       = 1'b0;
    data_operandA  = '0;
    data_operandB  = '0;
    mult_result    = '0;
    mult_exception = 1'b0;
    div_result     = '0;
    div_exception  = 1'b0;
    clearStats();
    repeat (3) @(negedge clock);
    check("rstResult", data_result, 32'd0);
    check("rstRdy", 32'(data_resultRDY), 32'd0);
    check("rstStrobes", {28'd0, mult_load, mult_enable, div_load, div_enable}, 32'd0);
    check("rstDpA", dp_operandA, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // 1: 7 * -3
    mult_result = 32'hFFFF_FFEB; mult_exception = 1'b0;
    clearStats();
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, c0);
    repeat (19) @(negedge clock);
    check("t1MultEnCnt", 32'(mEnCnt), 32'd16);
    check("t1MultEnFirst", 32'(mEnFirst), 32'(c0 + 1));
    check("t1MultEnLast", 32'(mEnLast), 32'(c0 + 16));
    check("t1DivEnCnt", 32'(dEnCnt), 32'd0);
    check("t1RdyCnt", 32'(rdyCnt), 32'd1);
    check("t1ResultHeld", data_result, 32'hFFFF_FFEB);

    // 2: 100 / 7, then 5 / 0
    div_result = 32'd14; div_exception = 1'b0;
    clearStats();
    issue(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, c0);
    repeat (35) @(negedge clock);
    check("t2DivEnCnt", 32'(dEnCnt), 32'd32);
    check("t2DivEnFirst", 32'(dEnFirst), 32'(c0 + 1));
    check("t2DivEnLast", 32'(dEnLast), 32'(c0 + 32));
    check("t2MultEnCnt", 32'(mEnCnt), 32'd0);
    check("t2RdyCnt", 32'(rdyCnt), 32'd1);
    div_result = 32'hFFFF_FFFF; div_exception = 1'b1;
    clearStats();
    issue(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, c0);
    repeat (35) @(negedge clock);
    check("t2bRdyCnt", 32'(rdyCnt), 32'd1);
    check("t2bExcHeld", 32'(data_exception), 32'd1);

    // 3: simultaneous MULT and DIV, MULT wins
    mult_result = 32'd12; mult_exception = 1'b0;
    div_result  = 32'd99; div_exception  = 1'b0;
    clearStats();
    issue(1'b1, 1'b1, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, c0);
    repeat (19) @(negedge clock);
    check("t3MultEnCnt", 32'(mEnCnt), 32'd16);
    check("t3DivEnCnt", 32'(dEnCnt), 32'd0);
    check("t3RdyCnt", 32'(rdyCnt), 32'd1);

    // 4: DIV aborted by a MULT in cycle 10 (0x10000 squared overflows)
    mult_result = 32'd0; mult_exception = 1'b1;
    div_result  = 32'd77; div_exception = 1'b0;
    clearStats();
    issue(1'b0, 1'b1, 32'd50, 32'd5, 1'b0, 32'd0, 1'b0, c0);
    repeat (8) @(negedge clock);
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 1'b1, c1);
    repeat (40) @(negedge clock);
    check("t4DivEnCnt", 32'(dEnCnt), 32'd10);
    check("t4DivEnLast", 32'(dEnLast), 32'(c0 + 10));
    check("t4MultEnFirst", 32'(mEnFirst), 32'(c0 + 11));
    check("t4MultEnCnt", 32'(mEnCnt), 32'd16);
    check("t4RdyCnt", 32'(rdyCnt), 32'd1);

    // 6: back-to-back MULT issued in the RDY cycle of the previous one
    mult_result = 32'd6; mult_exception = 1'b0;
    clearStats();
    issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0, c0);
    repeat (16) @(negedge clock);
    @(posedge clock);
    #1 mult_result = 32'd25;
    issue(1'b1, 1'b0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0, c1);
    check("t6SecondStart", 32'(c1 - c0), 32'd18);
    repeat (20) @(negedge clock);
    check("t6RdyCnt", 32'(rdyCnt), 32'd2);
    check("t6MultEnCnt", 32'(mEnCnt), 32'd32);
    check("t6ResultHeld", data_result, 32'd25);

    // 5: reset in cycle 9 of a MULT
    mult_result = 32'd1234; mult_exception = 1'b1;
    clearStats();
    issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, c0);
    repeat (8) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("t5RstResult", data_result, 32'd0);
    check("t5RstExc", 32'(data_exception), 32'd0);
    check("t5RstRdy", 32'(data_resultRDY), 32'd0);
    check("t5RstStrobes", {28'd0, mult_load, mult_enable, div_load, div_enable}, 32'd0);
    check("t5RstDpA", dp_operandA, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    clearStats();
    repeat (25) @(negedge clock);
    check("t5NoRdy", 32'(rdyCnt), 32'd0);
    check("t5NoEnable", 32'(mEnCnt + dEnCnt), 32'd0);

    check("sbDrained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
